dram_mux_model: RTL and testbench

Parametrised, clock-synchronous behavioural model of a multiplexed-address DRAM (4416-class and wider) for the board-level memory subsystems. Row and column are latched from a shared address bus under /RAS and /CAS, which the model samples on i_MCLK. Adds three things a fixed 16k×4 model lacks:
- a proper RAS/CAS state machine;
- fast-page-mode column sequencing;
- RAS-only and CAS-before-RAS (CBR) refresh detection, with an internal refresh row counter.

---
 rtl/dram_mux_model.sv | 220 ++++++++++++++++++++++
 tb/tb_dram_mux_model.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_mux_model.sv
// dram_mux_model: clock-synchronous model of a multiplexed-address DRAM.
// Row/column are latched from i_ADDR under /RAS and /CAS sampled on i_MCLK.
// Supports fast page mode, RAS-only refresh and CAS-before-RAS refresh with
// an internal refresh row counter.
// Optional: define DRAM_REFRESH_WATCHDOG_EN to build the refresh-interval
// watchdog driving o_REFRESH_ERR (tied low otherwise).
module dram_mux_model #(
    parameter int DW            = 4,
    parameter int AW            = 8,
    parameter int ROW_BITS      = 8,
    parameter int COL_BITS      = 6,
    parameter int COL_LSB       = 1,
    parameter int REFRESH_LIMIT = 65536
) (
    input  logic                i_MCLK,
    input  logic                i_RST_n,
    input  logic [AW-1:0]       i_ADDR,
    input  logic [DW-1:0]       i_DIN,
    output logic [DW-1:0]       o_DOUT,
    output logic                o_DOUT_VALID,
    input  logic                i_RAS_n,
    input  logic                i_CAS_n,
    input  logic                i_WR_n,
    input  logic                i_RD_n,
    output logic                o_REFRESH,
    output logic [ROW_BITS-1:0] o_REFRESH_ROW,
    output logic                o_REFRESH_ERR
);

    localparam int MEM_AW = ROW_BITS + COL_BITS;
    localparam int DEPTH  = 1 << MEM_AW;

    typedef enum logic [2:0] {
        IDLE,
        ROW_OPEN,
        COL_ACTIVE,
        PAGE_WAIT,
        CBR
    } state_t;

    state_t                state_q, state_d;
    logic                  ras_q, cas_q;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [ROW_BITS-1:0]   rcnt_q, rcnt_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  vld_q, vld_d;
    logic                  ref_q, ref_d;
    logic [ROW_BITS-1:0]   ref_row_q, ref_row_d;

    logic [DW-1:0]         mem_q [DEPTH];

    logic                  ras_fall, cas_fall;
    logic                  access, do_wr, do_rd;
    logic [MEM_AW-1:0]     mem_addr;

    // Strobe history resets low so a strobe held low through reset release
    // is never taken as a fall; the strobe must be seen high first.
    assign ras_fall = ras_q & ~i_RAS_n;
    assign cas_fall = cas_q & ~i_CAS_n;

    // Accesses only on COL_ACTIVE cycles after the latch cycle, strobes still low.
    assign access   = (state_q == COL_ACTIVE) & ~i_RAS_n & ~i_CAS_n;
    assign do_wr    = access & ~i_WR_n;
    assign do_rd    = access & i_WR_n & ~i_RD_n;
    assign mem_addr = {col_q, row_q};

    // Next-state, latches, refresh bookkeeping and read data.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        rcnt_d    = rcnt_q;
        ref_d     = 1'b0;
        ref_row_d = ref_row_q;
        vld_d     = do_rd;
        dout_d    = dout_q;
        if (do_rd) begin
            dout_d = mem_q[mem_addr];
        end
        case (state_q)
            IDLE: begin
                if (ras_fall) begin
                    if (!i_CAS_n) begin
                        // CAS already low (fresh or held): CBR / hidden refresh
                        state_d   = CBR;
                        ref_d     = 1'b1;
                        ref_row_d = rcnt_q;
                        rcnt_d    = rcnt_q + 1'b1;
                    end else begin
                        state_d = ROW_OPEN;
                        row_d   = i_ADDR[ROW_BITS-1:0];
                    end
                end
            end
            ROW_OPEN: begin
                if (i_RAS_n) begin
                    // Row opened and closed without a column: RAS-only refresh
                    state_d   = IDLE;
                    ref_d     = 1'b1;
                    ref_row_d = row_q;
                end else if (cas_fall) begin
                    state_d = COL_ACTIVE;
                    col_d   = i_ADDR[COL_LSB+COL_BITS-1:COL_LSB];
                end
            end
            COL_ACTIVE: begin
                if (i_RAS_n) begin
                    state_d = IDLE;
                end else if (i_CAS_n) begin
                    state_d = PAGE_WAIT;
                end
            end
            PAGE_WAIT: begin
                if (i_RAS_n) begin
                    state_d = IDLE;
                end else if (cas_fall) begin
                    // Fast page mode: new column, row retained
                    state_d = COL_ACTIVE;
                    col_d   = i_ADDR[COL_LSB+COL_BITS-1:COL_LSB];
                end
            end
            CBR: begin
                if (i_RAS_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, strobe history and registered outputs.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q   <= IDLE;
            ras_q     <= 1'b0;
            cas_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            rcnt_q    <= '0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            ref_q     <= 1'b0;
            ref_row_q <= '0;
        end else begin
            state_q   <= state_d;
            ras_q     <= i_RAS_n;
            cas_q     <= i_CAS_n;
            row_q     <= row_d;
            col_q     <= col_d;
            rcnt_q    <= rcnt_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            ref_q     <= ref_d;
            ref_row_q <= ref_row_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge i_MCLK) begin
        if (do_wr) begin
            mem_q[mem_addr] <= i_DIN;
        end
    end

    assign o_DOUT        = dout_q;
    assign o_DOUT_VALID  = vld_q;
    assign o_REFRESH     = ref_q;
    assign o_REFRESH_ROW = ref_row_q;

    // A zero or negative interval limit is meaningless; left empty as a marker.
    if (REFRESH_LIMIT < 1) begin : g_limit_invalid
    end

`ifdef DRAM_REFRESH_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        wd_err_q, wd_err_d;
    logic        wd_over;

    assign wd_over = (wd_cnt_q > 32'(REFRESH_LIMIT));

    // Saturating cycles-since-refresh counter and sticky error flag.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_err_d = wd_err_q | wd_over;
        if (ref_q) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != 32'hFFFF_FFFF) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
    end

    // Watchdog state register.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

`ifndef SYNTHESIS
    // Simulation warning on the cycle the error flag sets.
    always @(posedge i_MCLK) begin
        if (i_RST_n && wd_over && !wd_err_q) begin
            $display("dram_mux_model: warning, refresh interval exceeded %0d cycles", REFRESH_LIMIT);
        end
    end
`endif

    assign o_REFRESH_ERR = wd_err_q;
`else
    assign o_REFRESH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_mux_model.sv
// Directed testbench for dram_mux_model (default geometry, REFRESH_LIMIT=100).
module tb_dram_mux_model;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dout_valid;
    logic       ras_n, cas_n, wr_n, rd_n;
    logic       refresh;
    logic [7:0] refresh_row;
    logic       refresh_err;

    int checks = 0;
    int errors = 0;

    dram_mux_model #(
        .DW(4), .AW(8), .ROW_BITS(8), .COL_BITS(6), .COL_LSB(1), .REFRESH_LIMIT(100)
    ) dut (
        .i_MCLK        (clk),
        .i_RST_n       (rst_n),
        .i_ADDR        (addr),
        .i_DIN         (din),
        .o_DOUT        (dout),
        .o_DOUT_VALID  (dout_valid),
        .i_RAS_n       (ras_n),
        .i_CAS_n       (cas_n),
        .i_WR_n        (wr_n),
        .i_RD_n        (rd_n),
        .o_REFRESH     (refresh),
        .o_REFRESH_ROW (refresh_row),
        .o_REFRESH_ERR (refresh_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: outputs are stable #1 after the edge, inputs change there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic open_row(input logic [7:0] a);
        addr  = a;
        ras_n = 1'b0;
        cyc();
    endtask

    task automatic cas_low(input logic [7:0] a);
        addr  = a;
        cas_n = 1'b0;
        cyc();
    endtask

    task automatic close_all();
        ras_n = 1'b1;
        cas_n = 1'b1;
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic do_write(input logic [7:0] row, input logic [7:0] ca, input logic [3:0] d);
        open_row(row);
        cas_low(ca);
        din  = d;
        wr_n = 1'b0;
        cyc();
        close_all();
    endtask

    // Single read in its own RAS period; returns data, valid after the
    // access edge and valid one cycle later.
    task automatic do_read(input logic [7:0] row, input logic [7:0] ca,
                           output logic [3:0] d, output logic v1, output logic v2);
        open_row(row);
        cas_low(ca);
        rd_n = 1'b0;
        cyc();
        d    = dout;
        v1   = dout_valid;
        rd_n = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        cyc();
        v2   = dout_valid;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr = '0; din = '0;
        #3;
        checks++; if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (refresh !== 1'b0) begin errors++; $display("FAIL reset_refresh got %b exp 0", refresh); end
        checks++; if (refresh_row !== 8'h00) begin errors++; $display("FAIL reset_refresh_row got %h exp 00", refresh_row); end
        checks++; if (refresh_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", refresh_err); end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_write_read();
        logic [3:0] d; logic v1, v2;
        do_write(8'h12, 8'h0A, 4'hA);
        checks++; if (refresh !== 1'b0) begin errors++; $display("FAIL wr_no_refresh got %b exp 0", refresh); end
        do_read(8'h12, 8'h0A, d, v1, v2);
        checks++; if (d !== 4'hA) begin errors++; $display("FAIL rd_data got %h exp A", d); end
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL rd_valid got %b exp 1", v1); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL rd_valid_one_cycle got %b exp 0", v2); end
    endtask

    task automatic test_page_mode();
        logic [3:0] exp_d;
        open_row(8'h03);
        for (int c = 1; c <= 3; c++) begin
            cas_low(8'(c << 1));
            din  = 4'(c);
            wr_n = 1'b0;
            cyc();
            wr_n  = 1'b1;
            cas_n = 1'b1;
            cyc();
        end
        close_all();
        open_row(8'h03);
        for (int c = 1; c <= 3; c++) begin
            exp_d = 4'(c);
            cas_low(8'(c << 1));
            rd_n = 1'b0;
            cyc();
            checks++; if (dout !== exp_d) begin errors++; $display("FAIL page_rd_data col %0d got %h exp %h", c, dout, exp_d); end
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL page_rd_valid col %0d got %b exp 1", c, dout_valid); end
            rd_n  = 1'b1;
            cas_n = 1'b1;
            cyc();
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL page_valid_drop col %0d got %b exp 0", c, dout_valid); end
        end
        close_all();
    endtask

    task automatic test_collision();
        logic [3:0] d; logic v1, v2;
        open_row(8'h20);
        cas_low(8'h04);
        din  = 4'h5;
        wr_n = 1'b0;
        rd_n = 1'b0;
        cyc();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %b exp 0", dout_valid); end
        checks++; if (dout !== 4'h3) begin errors++; $display("FAIL coll_dout_hold got %h exp 3", dout); end
        close_all();
        do_read(8'h20, 8'h04, d, v1, v2);
        checks++; if (d !== 4'h5) begin errors++; $display("FAIL coll_write_done got %h exp 5", d); end
    endtask

    task automatic test_ras_only_refresh();
        int pulses;
        pulses = 0;
        open_row(8'h7F);
        checks++; if (refresh !== 1'b0) begin errors++; $display("FAIL rasonly_early got %b exp 0", refresh); end
        cyc();
        ras_n = 1'b1;
        cyc();
        checks++; if (refresh !== 1'b1) begin errors++; $display("FAIL rasonly_pulse got %b exp 1", refresh); end
        checks++; if (refresh_row !== 8'h7F) begin errors++; $display("FAIL rasonly_row got %h exp 7F", refresh_row); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (refresh === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rasonly_single_pulse extra %0d exp 0", pulses); end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] d; logic v1, v2;
        int vld_seen;
        vld_seen = 0;
        open_row(8'h21);
        cas_low(8'h04);
        din  = 4'h9;
        wr_n = 1'b0;
        cyc();
        wr_n = 1'b1;
        rd_n = 1'b0;
        cyc();
        checks++; if (dout !== 4'h9) begin errors++; $display("FAIL mid_pre_rd got %h exp 9", dout); end
        rst_n = 1'b0;
        #2;
        checks++; if (dout !== 4'h0) begin errors++; $display("FAIL mid_rst_dout got %h exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", dout_valid); end
        checks++; if (refresh_row !== 8'h00) begin errors++; $display("FAIL mid_rst_refresh_row got %h exp 00", refresh_row); end
        din  = 4'hF;
        wr_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (dout_valid !== 1'b0 || refresh !== 1'b0) vld_seen++;
        end
        checks++; if (vld_seen !== 0) begin errors++; $display("FAIL mid_no_access_after_release got %0d exp 0", vld_seen); end
        close_all();
        do_read(8'h21, 8'h04, d, v1, v2);
        checks++; if (d !== 4'h9) begin errors++; $display("FAIL mid_mem_unchanged got %h exp 9", d); end
    endtask

    task automatic test_cbr_refresh();
        logic [7:0] exp_row;
        logic [3:0] d; logic v1, v2;
        wr_n = 1'b0;
        din  = 4'hE;
        for (int i = 0; i <= 256; i++) begin
            exp_row = 8'(i);
            cas_n = 1'b0;
            cyc();
            ras_n = 1'b0;
            cyc();
            checks++; if (refresh !== 1'b1) begin errors++; $display("FAIL cbr_pulse iter %0d got %b exp 1", i, refresh); end
            checks++; if (refresh_row !== exp_row) begin errors++; $display("FAIL cbr_row iter %0d got %h exp %h", i, refresh_row, exp_row); end
            ras_n = 1'b1;
            cas_n = 1'b1;
            cyc();
            checks++; if (refresh !== 1'b0) begin errors++; $display("FAIL cbr_width iter %0d got %b exp 0", i, refresh); end
        end
        close_all();
        do_read(8'h12, 8'h0A, d, v1, v2);
        checks++; if (d !== 4'hA) begin errors++; $display("FAIL cbr_mem_a got %h exp A", d); end
        do_read(8'h03, 8'h04, d, v1, v2);
        checks++; if (d !== 4'h2) begin errors++; $display("FAIL cbr_mem_page got %h exp 2", d); end
    endtask

    task automatic test_watchdog();
        logic exp_err;
`ifdef DRAM_REFRESH_WATCHDOG_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 110; i++) cyc();
        checks++; if (refresh_err !== exp_err) begin errors++; $display("FAIL wd_set got %b exp %b", refresh_err, exp_err); end
        open_row(8'h55);
        ras_n = 1'b1;
        cyc();
        checks++; if (refresh !== 1'b1) begin errors++; $display("FAIL wd_refresh got %b exp 1", refresh); end
        cyc(); cyc();
        checks++; if (refresh_err !== exp_err) begin errors++; $display("FAIL wd_sticky got %b exp %b", refresh_err, exp_err); end
        rst_n = 1'b0;
        #2;
        checks++; if (refresh_err !== 1'b0) begin errors++; $display("FAIL wd_reset_clear got %b exp 0", refresh_err); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_page_mode();
        test_collision();
        test_ras_only_refresh();
        test_reset_mid_access();
        test_cbr_refresh();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
